// File: rtl/proj_fn_eval.sv
// proj_fn_eval: two-stage evaluator of a loadable N_IN-input truth table with per-query input projection.
// Define EVAL_CNT_EN to add the saturating cnt_ones counter of delivered r_y=1 results.
module proj_fn_eval #(
  parameter int N_IN  = 8,
  parameter int LD_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [LD_W-1:0]  ld_data,
  input  logic             ld_last,
  output logic             tbl_ok,
  output logic             ld_err,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [N_IN-1:0]  q_x,
  input  logic [N_IN-1:0]  q_mask,
  input  logic [N_IN-1:0]  q_val,
  output logic             r_valid,
  input  logic             r_ready,
  output logic             r_y,
  output logic [CNT_W-1:0] cnt_ones
);
  localparam int SIZE  = 2**N_IN;
  localparam int DEPTH = SIZE / LD_W;
  localparam int WP_W  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [SIZE-1:0] tbl;
  logic [WP_W-1:0] wp;
  logic [N_IN-1:0] s1_a;
  logic s1_v, s2_free, ld_acc, q_acc, loading, wp_end;
  assign s2_free  = ~r_valid | r_ready;
  assign ld_ready = ~s1_v & ~r_valid;
  assign ld_acc   = ld_valid & ld_ready;
  assign loading  = (wp != '0) | ld_acc;
  assign q_ready  = tbl_ok & ~loading & (~s1_v | s2_free);
  assign q_acc    = q_valid & q_ready;
  assign wp_end   = wp == WP_W'(DEPTH - 1);
  // Any word either ends the load cleanly, flags a length error, or continues it with both flags low.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tbl    <= '0;
      wp     <= '0;
      tbl_ok <= 1'b0;
      ld_err <= 1'b0;
    end else if (ld_acc) begin
      tbl[wp*LD_W +: LD_W] <= ld_data;
      wp     <= (ld_last | wp_end) ? '0 : wp + 1'b1;
      tbl_ok <= ld_last & wp_end;
      ld_err <= ld_last ^ wp_end;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      r_valid <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      if (~s1_v | s2_free) s1_v <= q_acc;
      if (q_acc) s1_a <= (q_x & ~q_mask) | (q_val & q_mask);
      if (s2_free) r_valid <= s1_v;
      if (s2_free & s1_v) r_y <= tbl[s1_a];
    end
`ifdef EVAL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_ones <= '0;
    else if (ld_acc & (wp == '0)) cnt_ones <= '0;
    else if (r_valid & r_ready & r_y & ~&cnt_ones) cnt_ones <= cnt_ones + 1'b1;
`else
  assign cnt_ones = '0;
`endif
endmodule

// File: tb/tb_proj_fn_eval.sv
// tb_proj_fn_eval: randomized scoreboard bench for proj_fn_eval against a flat truth-table model.
module tb_proj_fn_eval;
  logic clk = 0, rst_n = 0, ld_valid = 0, ld_last = 0, q_valid = 0, r_ready;
  logic [31:0] ld_data = '0;
  logic [7:0] q_x = '0, q_mask = '0, q_val = '0;
  logic ld_ready, tbl_ok, ld_err, q_ready, r_valid, r_y;
  logic [3:0] cnt_ones;
  typedef struct {logic y; int acc; bit lat;} exp_t;
  exp_t sb[$];
  logic [255:0] mtbl = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, rr_mode = 0, mcnt = 0;
  bit first = 0, prev_stall = 0;
  logic prev_y = 0;
`ifdef EVAL_CNT_EN
  localparam logic [3:0] CNT_SAT = 4'd15;
`else
  localparam logic [3:0] CNT_SAT = 4'd0;
`endif

  proj_fn_eval #(.N_IN(8), .LD_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .tbl_ok(tbl_ok), .ld_err(ld_err), .q_valid(q_valid), .q_ready(q_ready),
    .q_x(q_x), .q_mask(q_mask), .q_val(q_val), .r_valid(r_valid), .r_ready(r_ready),
    .r_y(r_y), .cnt_ones(cnt_ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      r_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? ~r_ready : rr_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
      mcnt = 0;
    end else begin
      chk("cnt_ones", 32'(cnt_ones), mcnt);
      if (prev_stall) begin
        chk("hold_valid", 32'(r_valid), 1);
        chk("hold_y", 32'(r_y), 32'(prev_y));
      end
      if (ld_valid && ld_ready && first) mcnt = 0;
      if (r_valid && r_ready) begin
        if (sb.size() == 0) chk("sb_size_on_result", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("r_y", 32'(r_y), 32'(e.y));
          if (e.lat) chk("latency", cyc - e.acc, 2);
`ifdef EVAL_CNT_EN
          if (e.y && mcnt < 15) mcnt++;
`endif
        end
      end
      prev_stall = r_valid && !r_ready;
      prev_y = r_y;
    end
  end

  task automatic load(input int n, input bit with_last, input logic [31:0] pat, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [31:0] w = rnd ? $urandom : pat;
      ld_valid = 1; ld_data = w; ld_last = with_last && i == n - 1; first = i == 0;
      @(negedge clk);
      while (!ld_ready && t < 200) begin @(negedge clk); t++; end
      chk("ld_accept", 32'(ld_ready), 1);
      if (ld_ready) mtbl[i*32 +: 32] = w;
      @(posedge clk);
      #1;
    end
    ld_valid = 0; ld_last = 0; first = 0;
  endtask

  task automatic query(input logic [7:0] x, input logic [7:0] m, input logic [7:0] v, input bit lat);
    int t = 0;
    exp_t e;
    q_valid = 1; q_x = x; q_mask = m; q_val = v;
    @(negedge clk);
    while (!q_ready && t < 200) begin @(negedge clk); t++; end
    chk("q_accept", 32'(q_ready), 1);
    if (q_ready) begin
      e.y = mtbl[(x & ~m) | (v & m)];
      e.acc = cyc;
      e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    q_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || r_valid) && t < 500) begin @(negedge clk); t++; end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] m;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_ld_ready", 32'(ld_ready), 1);
    chk("rst_q_ready", 32'(q_ready), 0);
    chk("rst_tbl_ok", 32'(tbl_ok), 0);
    chk("rst_ld_err", 32'(ld_err), 0);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_r_y", 32'(r_y), 0);
    chk("rst_cnt", 32'(cnt_ones), 0);
    @(posedge clk);
    #1;
    load(8, 1, 32'hE8E8E8E8, 0);
    chk("maj_tbl_ok", 32'(tbl_ok), 1);
    chk("maj_ld_err", 32'(ld_err), 0);
    query(8'h03, 8'h00, 8'h00, 1);
    drain();
    query(8'h01, 8'h04, 8'h04, 0);
    query(8'h01, 8'h04, 8'h00, 0);
    drain();
    rr_mode = 1;
    repeat (16) query(8'($urandom), 8'h00, 8'h00, 0);
    drain();
    rr_mode = 0;
    load(3, 1, 32'h0, 1);
    chk("short_ld_err", 32'(ld_err), 1);
    chk("short_tbl_ok", 32'(tbl_ok), 0);
    q_valid = 1;
    #1 chk("short_q_ready", 32'(q_ready), 0);
    q_valid = 0;
    load(8, 0, 32'h0, 1);
    chk("nolast_ld_err", 32'(ld_err), 1);
    chk("nolast_tbl_ok", 32'(tbl_ok), 0);
    load(8, 1, 32'hE8E8E8E8, 0);
    chk("reload_ld_err", 32'(ld_err), 0);
    chk("reload_tbl_ok", 32'(tbl_ok), 1);
    ld_valid = 1; q_valid = 1;
    #1;
    chk("prio_ld_ready", 32'(ld_ready), 1);
    chk("prio_q_ready", 32'(q_ready), 0);
    ld_valid = 0; q_valid = 0;
    for (int i = 0; i < 8; i++) query(8'($urandom), 8'hFF, 8'($urandom), 0);
    drain();
    load(8, 1, 32'hE8E8E8E8, 0);
    repeat (20) query(8'($urandom) | 8'h07, 8'h00, 8'h00, 0);
    drain();
    chk("cnt_final", 32'(cnt_ones), 32'(CNT_SAT));
    rr_mode = 2;
    query(8'h07, 8'h00, 8'h00, 0);
    query(8'h00, 8'h00, 8'h00, 0);
    rst_n = 0;
    sb.delete();
    #1;
    chk("midrst_r_valid", 32'(r_valid), 0);
    chk("midrst_tbl_ok", 32'(tbl_ok), 0);
    chk("midrst_cnt", 32'(cnt_ones), 0);
    mtbl = '0;
    rr_mode = 0;
    @(posedge clk);
    #1 rst_n = 1;
    #1 chk("postrst_q_ready", 32'(q_ready), 0);
    load(8, 1, 32'h0, 1);
    rr_mode = 3;
    repeat (150) begin
      m = $urandom_range(0, 7) == 0 ? 8'hFF : 8'($urandom);
      query(8'($urandom), m, 8'($urandom), 0);
    end
    drain();
    rr_mode = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
